// File: rtl/ofm_drain.sv
// Drains the CONV_NUM parallel OFM memories after a convolution run onto one
// byte-wide valid/ready stream, address-major (all lanes of an address, then the next).
module ofm_drain #(
  parameter int CONV_NUM = 4,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int OFM_LEN  = 1024,
  localparam int LANE_W  = (CONV_NUM > 1) ? $clog2(CONV_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done,
  output logic [CONV_NUM*ADDR_W-1:0] ofm_addr,
  input  logic [CONV_NUM*DATA_W-1:0] ofm_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [LANE_W-1:0]          m_lane,
  output logic [ADDR_W-1:0]          m_addr,
  output logic                       m_last,
  output logic                       busy,
  output logic                       drained,
  output logic [1:0]                 state_dbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] SEND    = 2'd3;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(CONV_NUM - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OFM_LEN - 1);

  logic [1:0]                 state;
  logic                       done_q;
  logic [ADDR_W-1:0]          addr_cnt;
  logic [LANE_W-1:0]          lane_cnt;
  logic [CONV_NUM*DATA_W-1:0] hold;
  logic                       send;
  logic                       last_word;

  assign send      = (state == SEND);
  assign last_word = (lane_cnt == LAST_LANE) && (addr_cnt == LAST_ADDR);

  // Stream handshake: a word transfers on a rising edge with m_valid && m_ready;
  // until then m_valid stays high and m_data/m_lane/m_addr/m_last hold their values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      addr_cnt <= '0;
      lane_cnt <= '0;
      hold     <= '0;
      drained  <= 1'b0;
    end else begin
      done_q  <= done;
      drained <= 1'b0;
      case (state)
        IDLE: begin
          // done_q tracks done in every state, so edges seen while busy are lost.
          if (done && !done_q) begin
            addr_cnt <= '0;
            lane_cnt <= '0;
            state    <= FETCH;
          end
        end
        FETCH:   state <= CAPTURE;
        CAPTURE: begin
          hold  <= ofm_out;
          state <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            if (lane_cnt != LAST_LANE) begin
              lane_cnt <= lane_cnt + 1'b1;
            end else if (addr_cnt != LAST_ADDR) begin
              lane_cnt <= '0;
              addr_cnt <= addr_cnt + 1'b1;
              state    <= FETCH;
            end else begin
              drained <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything below decodes registered state only; m_ready never reaches m_valid.
  assign m_valid   = send;
  assign m_data    = send ? hold[DATA_W*int'(lane_cnt) +: DATA_W] : '0;
  assign m_lane    = send ? lane_cnt : '0;
  assign m_addr    = send ? addr_cnt : '0;
  assign m_last    = send && last_word;
  assign busy      = (state != IDLE);
  assign ofm_addr  = busy ? {CONV_NUM{addr_cnt}} : '0;
  assign state_dbg = state;

endmodule
